// File: rtl/note_sequencer.sv
// Song-level driver: walks a 32-entry song in an external synchronous ROM and hands each
// note/duration to the note player with a one-cycle load strobe, waiting on its done flag.
module note_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        play,
  input  logic        restart,
  input  logic [1:0]  song,
  input  logic        done_with_note,
  input  logic [11:0] rom_data,
  output logic [6:0]  rom_addr,
  output logic [5:0]  note_to_load,
  output logic [5:0]  duration_to_load,
  output logic        load_new_note,
  output logic [4:0]  note_index,
  output logic        song_done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_ROM,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE,
    DONE
  } state_t;

  state_t     state, state_nxt;
  logic [4:0] idx, idx_nxt;
  logic [1:0] song_q, song_nxt;
  logic       capture, clear_note;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      idx              <= 5'd0;
      song_q           <= 2'd0;
      note_to_load     <= 6'd0;
      duration_to_load <= 6'd0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      song_q <= song_nxt;
      if (clear_note) begin
        note_to_load     <= 6'd0;
        duration_to_load <= 6'd0;
      end else if (capture) begin
        note_to_load     <= rom_data[11:6];
        duration_to_load <= rom_data[5:0];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    song_nxt   = song_q;
    capture    = 1'b0;
    clear_note = 1'b0;
    if (restart) begin
      state_nxt  = IDLE;
      idx_nxt    = 5'd0;
      clear_note = 1'b1;
    end else if (!play) begin
      // Pause freezes everything except a finished song, which drops back to IDLE.
      if (state == DONE) state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          song_nxt  = song;
          idx_nxt   = 5'd0;
          state_nxt = FETCH;
        end
        FETCH:     state_nxt = WAIT_ROM;
        WAIT_ROM: begin
          capture   = 1'b1;
          state_nxt = (rom_data[5:0] == 6'd0) ? DONE : LOAD;
        end
        LOAD:      state_nxt = WAIT_BUSY;
        WAIT_BUSY: state_nxt = WAIT_DONE;
        WAIT_DONE: begin
          if (done_with_note) begin
            if (idx == 5'd31) begin
              state_nxt = DONE;
            end else begin
              idx_nxt   = idx + 5'd1;
              state_nxt = FETCH;
            end
          end
        end
        DONE:      state_nxt = DONE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  assign rom_addr      = {song_q, idx};
  assign note_index    = idx;
  assign load_new_note = (state == LOAD) && play;
  assign song_done     = (state == DONE);

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with a behavioural song ROM and note-player model.
module tb_note_sequencer;

  logic        clk;
  logic        reset_n;
  logic        play;
  logic        restart;
  logic [1:0]  song;
  logic        done_with_note;
  logic [11:0] rom_data;
  logic [6:0]  rom_addr;
  logic [5:0]  note_to_load;
  logic [5:0]  duration_to_load;
  logic        load_new_note;
  logic [4:0]  note_index;
  logic        song_done;

  logic [11:0] rom [128];
  logic [5:0]  player_cnt;
  int          n_checks;
  int          n_fail;
  int          n_strobes;

  note_sequencer dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .play             (play),
    .restart          (restart),
    .song             (song),
    .done_with_note   (done_with_note),
    .rom_data         (rom_data),
    .rom_addr         (rom_addr),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .load_new_note    (load_new_note),
    .note_index       (note_index),
    .song_done        (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  // Player: loads the duration on a strobe, counts down one per beat, done at zero.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)          player_cnt <= 6'd0;
    else if (load_new_note) player_cnt <= duration_to_load;
    else if (player_cnt != 6'd0) player_cnt <= player_cnt - 6'd1;
  end
  assign done_with_note = (player_cnt == 6'd0);

  always @(posedge clk) if (load_new_note) n_strobes <= n_strobes + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advances at least one cycle, then until a strobe; returns the cycles taken.
  task automatic wait_next(input int max, output int n);
    n = 1;
    tick();
    while (!load_new_note && n < max) begin
      tick();
      n++;
    end
    check("strobe_seen", {31'd0, load_new_note}, 32'd1);
  endtask

  int gap;
  int s0;

  initial begin
    n_checks = 0;
    n_fail = 0;
    n_strobes = 0;
    for (int i = 0; i < 128; i++) rom[i] = 12'd0;
    rom[0] = {6'd10, 6'd3};
    rom[1] = {6'd20, 6'd2};
    for (int i = 0; i < 32; i++) begin
      rom[32 + i] = {6'(i + 1), 6'd1};
      rom[96 + i] = {6'(40 + i), 6'd3};
    end
    rom[64] = {6'd7, 6'd0};
    reset_n = 1'b0;
    play = 1'b0;
    restart = 1'b0;
    song = 2'd0;
    rom_data = 12'd0;
    tick();
    tick();
    check("rst_rom_addr", {25'd0, rom_addr}, 32'd0);
    check("rst_note", {26'd0, note_to_load}, 32'd0);
    check("rst_dur", {26'd0, duration_to_load}, 32'd0);
    check("rst_load", {31'd0, load_new_note}, 32'd0);
    check("rst_index", {27'd0, note_index}, 32'd0);
    check("rst_done", {31'd0, song_done}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Song 0: two notes then an end marker.
    play = 1'b1;
    wait_next(20, gap);
    check("s0_first_latency", gap, 32'd3);
    check("s0_n1_note", {26'd0, note_to_load}, 32'd10);
    check("s0_n1_dur", {26'd0, duration_to_load}, 32'd3);
    wait_next(20, gap);
    check("s0_gap", gap, 32'd7);
    check("s0_n2_note", {26'd0, note_to_load}, 32'd20);
    check("s0_n2_dur", {26'd0, duration_to_load}, 32'd2);
    for (int k = 0; k < 5; k++) tick();
    check("s0_not_done_yet", {31'd0, song_done}, 32'd0);
    tick();
    check("s0_song_done", {31'd0, song_done}, 32'd1);
    check("s0_strobes", n_strobes, 32'd2);
    play = 1'b0;
    tick();
    check("s0_idle", {31'd0, song_done}, 32'd0);

    // Song 1: full 32 entries; song select changes to 2 mid-song.
    song = 2'd1;
    play = 1'b1;
    s0 = n_strobes;
    for (int i = 0; i < 32; i++) begin
      wait_next(20, gap);
      check("s1_gap", gap, (i == 0) ? 32'd3 : 32'd5);
      check("s1_index", {27'd0, note_index}, i);
      check("s1_addr", {25'd0, rom_addr}, 32'h20 + i);
      check("s1_note", {26'd0, note_to_load}, i + 1);
      if (i == 5) song = 2'd2;
    end
    tick();
    tick();
    tick();
    check("s1_done", {31'd0, song_done}, 32'd1);
    check("s1_addr_final", {25'd0, rom_addr}, 32'h3F);
    for (int k = 0; k < 4; k++) tick();
    check("s1_strobes", n_strobes - s0, 32'd32);
    check("s1_still_done", {31'd0, song_done}, 32'd1);

    // Song 2: first entry is an end marker.
    play = 1'b0;
    tick();
    check("s2_idle", {31'd0, song_done}, 32'd0);
    play = 1'b1;
    s0 = n_strobes;
    tick();
    check("s2_fetch_addr", {25'd0, rom_addr}, 32'h40);
    tick();
    tick();
    check("s2_done", {31'd0, song_done}, 32'd1);
    check("s2_marker_note", {26'd0, note_to_load}, 32'd7);
    check("s2_marker_dur", {26'd0, duration_to_load}, 32'd0);
    check("s2_no_strobe", n_strobes - s0, 32'd0);

    // Pause during LOAD.
    play = 1'b0;
    restart = 1'b1;
    song = 2'd0;
    tick();
    restart = 1'b0;
    play = 1'b1;
    tick();
    tick();
    tick();
    s0 = n_strobes;
    play = 1'b0;
    #1;
    check("pause_load_low", {31'd0, load_new_note}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("pause_hold", {31'd0, load_new_note}, 32'd0);
    end
    play = 1'b1;
    #1;
    check("resume_load", {31'd0, load_new_note}, 32'd1);
    check("resume_note", {26'd0, note_to_load}, 32'd10);
    check("resume_dur", {26'd0, duration_to_load}, 32'd3);
    tick();
    check("resume_one_strobe", n_strobes - s0, 32'd1);

    // Restart during WAIT_DONE of note 4 on song 3.
    play = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    song = 2'd3;
    play = 1'b1;
    for (int i = 0; i < 5; i++) wait_next(30, gap);
    check("s3_n4_index", {27'd0, note_index}, 32'd4);
    tick();
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("rs_index", {27'd0, note_index}, 32'd0);
    check("rs_addr_low", {27'd0, rom_addr[4:0]}, 32'd0);
    check("rs_note", {26'd0, note_to_load}, 32'd0);
    check("rs_dur", {26'd0, duration_to_load}, 32'd0);
    check("rs_load", {31'd0, load_new_note}, 32'd0);
    tick();
    tick();
    tick();
    check("rs_restrobe", {31'd0, load_new_note}, 32'd1);
    check("rs_note0", {26'd0, note_to_load}, 32'd40);

    // Asynchronous reset in the middle of LOAD.
    s0 = n_strobes;
    reset_n = 1'b0;
    #1;
    check("arst_load", {31'd0, load_new_note}, 32'd0);
    check("arst_note", {26'd0, note_to_load}, 32'd0);
    check("arst_addr", {25'd0, rom_addr}, 32'd0);
    tick();
    check("arst_no_strobe", n_strobes - s0, 32'd0);
    reset_n = 1'b1;
    play = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Song-level driver for the note player: walks a song stored in an external synchronous song ROM, presents each note/duration pair to the note player with a one-cycle `load_new_note` pulse, and waits on the player's `done_with_note` before fetching the next entry. It is the initiator side of the note-player load/done handshake and sits between the top-level play/song controls and the note player.

## Interface
- No parameters. The song length is fixed at 32 entries, and there are 4 songs.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `play`  in  1  level; 1 = advance, 0 = pause (freeze).
- `restart`  in  1  synchronous single-cycle request: abandon the current song and return to IDLE.
- `song`  in  2  song select; sampled only when leaving IDLE.
- `done_with_note`  in  1  from the note player; 1 when its duration count is 0.
- `rom_data`  in  12  song ROM output {note[11:6], duration[5:0]}; valid 1 cycle after `rom_addr`.
- `rom_addr`  out  7  {song_q[1:0], idx[4:0]}.
- `note_to_load`  out  6  registered note code.
- `duration_to_load`  out  6  registered duration in beats.
- `load_new_note`  out  1  single-cycle load strobe to the note player.
- `note_index`  out  5  current entry index `idx`.
- `song_done`  out  1  level; high while in DONE.

## Operation
- States: IDLE, FETCH, WAIT_ROM, LOAD, WAIT_BUSY, WAIT_DONE, DONE.
- Priority order each cycle:
  - `restart` overrides everything: state←IDLE, idx←0, `note_to_load`←0, `duration_to_load`←0.
  - Otherwise, with `play`=0 every state holds, except DONE, which goes to IDLE.
- IDLE: if `play`, then song_q←`song`, idx←0, →FETCH.
- FETCH: `rom_addr` is presented. →WAIT_ROM.
- WAIT_ROM: capture `rom_data` into `note_to_load` and `duration_to_load`.
  - If the duration field is 0, the entry is an end-of-song marker: →DONE, with no load issued.
  - Otherwise →LOAD.
- LOAD: `load_new_note`=1 for exactly this cycle. →WAIT_BUSY.
- WAIT_BUSY: one-cycle guard while the player's count register takes the new duration. `done_with_note` is ignored here. →WAIT_DONE.
- WAIT_DONE: when `done_with_note`=1:
  - if idx=31, →DONE;
  - otherwise idx←idx+1, →FETCH.
- DONE: `song_done`=1. Leaves to IDLE only when `play`=0 or `restart`=1.
- `load_new_note` = (state==LOAD) & `play`. A paused LOAD issues no strobe and retries when `play` returns.
- `note_to_load` and `duration_to_load` hold their value from the WAIT_ROM capture until the next capture, `restart`, or reset.
- idx is 5 bits and never wraps silently: idx=31 always leads to DONE.
- Changing `song` mid-song has no effect until the next IDLE exit.

## Timing
- Reset (`reset_n`=0, async): state=IDLE, idx=0, song_q=0. All outputs read 0: `rom_addr`, `note_to_load`, `duration_to_load`, `load_new_note`, `note_index`, `song_done`.
- Start latency: `play` high in IDLE at cycle t gives FETCH at t+1, WAIT_ROM at t+2, and `load_new_note` at t+3.
- Inter-note gap: `done_with_note`=1 seen in WAIT_DONE at cycle d gives the next `load_new_note` at d+3.
- Note, duration and `rom_addr` are stable during the LOAD cycle and after it.
- `play` falling in any mid-song state freezes the FSM on the next edge. Resuming continues from the same state with no lost or duplicated strobes.
- `restart` together with `play`=1 in the same cycle: the FSM goes to IDLE, and the next cycle starts a new song from the current `song`.
- Reset asserted mid-note: outputs clear immediately and asynchronously; no strobe is emitted during reset.

## Test plan
- Reset, then ROM song 0 = {(n=10,d=3),(n=20,d=2),(0,0)}, with a player model whose `done_with_note` falls the cycle after a load and rises after d beats.
  - Required: load strobes carry 10/3 and then 20/2, the first strobe lands at t+3, and `song_done`=1 after the second note's done.
- Song 1 with all 32 entries nonzero.
  - Required: exactly 32 strobes, `note_index` runs 0..31, `rom_addr` runs 0x20..0x3F, then DONE with no 33rd fetch.
- `play` drops during LOAD for 5 cycles, then rises.
  - Required: no strobe while low, exactly one strobe after resume, same note/duration.
- `restart` pulsed during WAIT_DONE of note 4.
  - Required: IDLE next cycle, `note_index`=0, outputs 0; with `play`=1, a new strobe for entry 0 three cycles later.
- `song` changed 1→2 mid-song.
  - Required: `rom_addr` upper bits stay 1 until DONE; after a `play` 0→1 cycle, fetches use song 2.
- First entry has duration 0.
  - Required: no strobe, `song_done`=1 two cycles after FETCH.
